sdram_req_arb: RTL and testbench
================================

Name: sdram_req_arb

Overview:
- Parametrised N-channel request arbiter in front of the SDRAM controller core's application port, on the memory clock.
- Generalises the current fixed pair (one video-read requester, one FTDI-write requester, combinational OR/mux, ad-hoc read-tail guard) to NCH channels with per-request read/write direction and length.
- Channel 0 has fixed top priority for the video line fetcher. Other channels rotate round-robin.
- Keeps an in-flight read tag queue so read data is steered back to the channel that issued the read.

Parameters:
- NCH, 3: number of requesting channels (2..8); channel 0 has fixed priority.
- AW, 25: request address width.
- DW, 16: data width.
- LENW, 9: burst length field width.
- RDQ_DEPTH, 4: maximum read bursts accepted but not yet fully returned (power of 2).
- RD_TAIL, 2: idle cycles required after the last app_rd_valid before a write may be issued.

Ports:
- clk  in  1  memory clock
- reset  in  1  asynchronous, active-high
- mem_ready  in  1  controller init done; no grant while low
- ch_req  in  NCH  per-channel request level, held until ch_ack
- ch_wr_n  in  NCH  1 = read, 0 = write
- ch_addr  in  NCH*AW  packed request addresses
- ch_len  in  NCH*LENW  packed burst lengths (0 is illegal, treated as 1)
- ch_wdata  in  NCH*DW  packed write data
- ch_ack  out  NCH  one-cycle accept pulse to the granted channel
- ch_wr_next  out  NCH  write-data advance strobe to the write owner
- ch_rd_valid  out  NCH  read-data valid, steered by tag
- ch_rd_last  out  NCH  last word of the steered burst
- rd_data  out  DW  registered copy of app_rd_data, shared by all channels
- app_req  out  1
- app_req_addr  out  AW
- app_req_len  out  LENW
- app_req_wr_n  out  1
- app_req_ack  in  1
- app_wr_data  out  DW  combinational mux of ch_wdata by write owner
- app_wr_next_req  in  1
- app_last_wr  in  1
- app_rd_valid  in  1
- app_last_rd  in  1
- app_rd_data  in  DW
- rdq_level  out  $clog2(RDQ_DEPTH)+1  outstanding read bursts

Behaviour:
- Reset values:
  - All outputs 0; app_req_wr_n = 1.
  - FSM in IDLE, round-robin pointer = 1, read queue empty, tail counter = 0.
- FSM states IDLE, ISSUE, WDATA.
- IDLE:
  - If mem_ready, evaluate eligible channels:
    - A read is eligible iff the read queue is not full.
    - A write is eligible iff the read queue is empty and the tail counter is 0.
  - Channel 0 wins if eligible. Otherwise the first eligible channel at or after the rotating pointer wins.
  - On a win, latch the channel's addr, len and wr_n into the app_* registers, assert app_req next cycle, go to ISSUE.
- ISSUE:
  - app_req and the latched fields are held stable until app_req_ack is sampled 1.
  - That same cycle: ch_ack[owner] pulses; pointer moves to owner+1, skipping 0 and wrapping.
  - Read: push owner onto the tag queue, return to IDLE. The next grant is possible one cycle later, so reads are pipelined.
  - Write: go to WDATA.
- WDATA:
  - ch_wr_next[owner] = app_wr_next_req (combinational).
  - app_wr_data = owner's ch_wdata.
  - Exit to IDLE on app_last_wr.
- Read return:
  - Each app_rd_valid word drives ch_rd_valid[head tag], registered by 1 cycle together with rd_data.
  - app_last_rd registers into ch_rd_last and pops the queue.
  - app_rd_valid with an empty queue is dropped and sets an internal sticky error bit for simulation assertion.
- Tail counter: loads RD_TAIL on every app_rd_valid, decrements to 0 otherwise.
- Simultaneous push and pop: level unchanged, both pointers advance.
- A channel deasserting ch_req before its ack is a protocol violation; the latched request still completes.
- mem_ready falling mid-operation: the current transaction completes, then no new grants.
- reset mid-burst: immediate return to reset state. Queue contents are discarded.

Decomposition:
- Shared package: FSM state encoding, the tag width $clog2(NCH), and the illegal-length rule constant.
- One sub-module, sdram_tag_fifo: a synchronous RDQ_DEPTH x tag FIFO with push/pop/level/full/empty.
- The round-robin pick stays inline as a function.

Test Plan:
- Read pipelining: ch0 read addr 0x000100 len 8, ch1 read addr 0x000200 len 8 back-to-back, controller acks in consecutive grants -> two app_req handshakes; rd_valid words 0..7 on ch0 then 8..15 on ch1; rdq_level peaks at 2, ends at 0.
- Priority: ch0 and ch2 request in the same cycle -> ch0 acked first, ch2 next IDLE evaluation.
- Round-robin: ch1 and ch2 requesting continuously with ch0 idle -> grants alternate ch1, ch2, ch1, ...
- Write guard: ch1 write len 1 while a ch0 read is outstanding -> no app_req until the queue is empty plus RD_TAIL=2 idle cycles after the final app_rd_valid; then app_req_wr_n = 0 and app_wr_data = ch1 word.
- Queue full: 4 reads acked, no data returned -> a 5th read is held off; after one app_last_rd the 5th is granted within 2 cycles.
- Reset mid-write: assert reset during WDATA -> all outputs 0, app_req_wr_n = 1 in the same cycle; after release the next request is granted normally.

Source files
------------

// File: rtl/sdram_req_arb_pkg.sv
// Shared types and constants for the SDRAM request arbiter.
// Tag width is a function of the channel count so one package serves every NCH.
package sdram_req_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WDATA = 2'd2
    } arb_state_e;

    // A zero burst length from a requester is issued as this length instead.
    localparam int unsigned LEN_ZERO_SUBST = 1;

    function automatic int unsigned tag_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// Read-tag FIFO: remembers which channel owns each outstanding read burst.
// DEPTH must be a power of two so the pointers wrap naturally.
module sdram_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   level_q, level_d;
    logic          do_push, do_pop;

    always_comb begin
        empty    = (level_q == '0);
        full     = level_q[PW];
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/sdram_req_arb.sv
// N-channel request arbiter for the SDRAM controller application port.
// Channel 0 has fixed priority; others rotate. Read data is steered by tag.
module sdram_req_arb
    import sdram_req_arb_pkg::*;
#(
    parameter int unsigned NCH       = 3,
    parameter int unsigned AW        = 25,
    parameter int unsigned DW        = 16,
    parameter int unsigned LENW      = 9,
    parameter int unsigned RDQ_DEPTH = 4,
    parameter int unsigned RD_TAIL   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_ready,
    input  logic [NCH-1:0]             ch_req,
    input  logic [NCH-1:0]             ch_wr_n,
    input  logic [NCH*AW-1:0]          ch_addr,
    input  logic [NCH*LENW-1:0]        ch_len,
    input  logic [NCH*DW-1:0]          ch_wdata,
    output logic [NCH-1:0]             ch_ack,
    output logic [NCH-1:0]             ch_wr_next,
    output logic [NCH-1:0]             ch_rd_valid,
    output logic [NCH-1:0]             ch_rd_last,
    output logic [DW-1:0]              rd_data,
    output logic                       app_req,
    output logic [AW-1:0]              app_req_addr,
    output logic [LENW-1:0]            app_req_len,
    output logic                       app_req_wr_n,
    input  logic                       app_req_ack,
    output logic [DW-1:0]              app_wr_data,
    input  logic                       app_wr_next_req,
    input  logic                       app_last_wr,
    input  logic                       app_rd_valid,
    input  logic                       app_last_rd,
    input  logic [DW-1:0]              app_rd_data,
    output logic [$clog2(RDQ_DEPTH):0] rdq_level
);
    localparam int unsigned TW    = tag_width(NCH);
    localparam int unsigned TAILW = $clog2(RD_TAIL + 2);

    arb_state_e     state_q, state_d;
    logic [TW-1:0]  owner_q, owner_d;
    logic [TW-1:0]  ptr_q, ptr_d;
    logic           app_req_q, app_req_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [LENW-1:0] len_q, len_d;
    logic           wr_n_q, wr_n_d;
    logic [TAILW-1:0] tail_q, tail_d;
    logic [NCH-1:0] rd_valid_q, rd_valid_d;
    logic [NCH-1:0] rd_last_q, rd_last_d;
    logic [DW-1:0]  rd_data_q, rd_data_d;
    logic           rd_err_q, rd_err_d;

    logic [NCH-1:0] elig;
    logic [TW:0]    pick;
    logic [TW-1:0]  win;
    logic [LENW-1:0] win_len;
    logic           q_push, q_pop, q_full, q_empty;
    logic [TW-1:0]  q_head;

    // Returns {found, index}: channel 0 first, then first eligible at/after ptr.
    function automatic logic [TW:0] rr_pick(input logic [NCH-1:0] e, input logic [TW-1:0] p);
        logic [TW:0]   res;
        logic [TW-1:0] sel;
        int unsigned   idx;
        res = '0;
        if (e[0]) begin
            res = {1'b1, {TW{1'b0}}};
        end else begin
            for (int unsigned k = 0; k < NCH - 1; k++) begin
                idx = 1 + (32'(p) - 1 + k) % (NCH - 1);
                sel = idx[TW-1:0];
                if (!res[TW] && e[sel]) res = {1'b1, sel};
            end
        end
        return res;
    endfunction

    function automatic logic [TW-1:0] next_ptr(input logic [TW-1:0] o);
        if (o >= TW'(NCH - 1)) return TW'(1);
        return o + 1'b1;
    endfunction

    sdram_tag_fifo #(
        .DEPTH (RDQ_DEPTH),
        .W     (TW)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .din   (owner_q),
        .dout  (q_head),
        .level (rdq_level),
        .full  (q_full),
        .empty (q_empty)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        app_req_d   = app_req_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wr_n_d      = wr_n_q;
        q_push      = 1'b0;
        ch_ack      = '0;
        ch_wr_next  = '0;
        app_wr_data = '0;
        elig        = '0;
        win         = '0;
        win_len     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            elig[i] = ch_req[i] && (ch_wr_n[i] ? !q_full : (q_empty && tail_q == '0));
        end
        pick = rr_pick(elig, ptr_q);
        case (state_q)
            ST_IDLE: begin
                if (mem_ready && pick[TW]) begin
                    win       = pick[TW-1:0];
                    win_len   = ch_len[win*LENW +: LENW];
                    owner_d   = win;
                    app_req_d = 1'b1;
                    addr_d    = ch_addr[win*AW +: AW];
                    len_d     = (win_len == '0) ? LENW'(LEN_ZERO_SUBST) : win_len;
                    wr_n_d    = ch_wr_n[win];
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (app_req_ack) begin
                    ch_ack    = NCH'(1) << owner_q;
                    app_req_d = 1'b0;
                    ptr_d     = next_ptr(owner_q);
                    if (wr_n_q) begin
                        q_push  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
            end
            ST_WDATA: begin
                ch_wr_next = NCH'(app_wr_next_req) << owner_q;
                if (app_last_wr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!wr_n_q && state_q != ST_IDLE) begin
            app_wr_data = ch_wdata[owner_q*DW +: DW];
        end
    end

    // Return path: tail counter re-arms on every returned word, not just the last.
    always_comb begin
        rd_valid_d = '0;
        rd_last_d  = '0;
        rd_data_d  = rd_data_q;
        rd_err_d   = rd_err_q;
        q_pop      = 1'b0;
        tail_d     = (tail_q != '0) ? tail_q - 1'b1 : '0;
        if (app_rd_valid) begin
            tail_d = TAILW'(RD_TAIL);
            if (q_empty) begin
                rd_err_d = 1'b1;
            end else begin
                rd_valid_d = NCH'(1) << q_head;
                rd_last_d  = NCH'(app_last_rd) << q_head;
                rd_data_d  = app_rd_data;
                q_pop      = app_last_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ptr_q      <= TW'(1);
            app_req_q  <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            wr_n_q     <= 1'b1;
            tail_q     <= '0;
            rd_valid_q <= '0;
            rd_last_q  <= '0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            app_req_q  <= app_req_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wr_n_q     <= wr_n_d;
            tail_q     <= tail_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assert property (@(posedge clk) disable iff (reset) !rd_err_q);

    assign app_req      = app_req_q;
    assign app_req_addr = addr_q;
    assign app_req_len  = len_q;
    assign app_req_wr_n = wr_n_q;
    assign ch_rd_valid  = rd_valid_q;
    assign ch_rd_last   = rd_last_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_sdram_req_arb.sv
// Directed-sequence bench with randomized fields, checked against a queue-based
// model of grant order, tag steering, queue level and write-after-read spacing.
module tb_sdram_req_arb;
    localparam int NCH = 3, AW = 25, DW = 16, LENW = 9, RDQ_DEPTH = 4, RD_TAIL = 2;
    localparam int QLW = $clog2(RDQ_DEPTH) + 1;

    logic clk = 1'b0;
    logic reset, mem_ready;
    logic [NCH-1:0] ch_req, ch_wr_n, ch_ack, ch_wr_next, ch_rd_valid, ch_rd_last;
    logic [AW-1:0]   r_addr  [NCH];
    logic [LENW-1:0] r_len   [NCH];
    logic [DW-1:0]   r_wdata [NCH];
    logic [NCH*AW-1:0]   ch_addr;
    logic [NCH*LENW-1:0] ch_len;
    logic [NCH*DW-1:0]   ch_wdata;
    logic [DW-1:0]   rd_data, app_wr_data, app_rd_data;
    logic            app_req, app_req_wr_n, app_req_ack;
    logic [AW-1:0]   app_req_addr;
    logic [LENW-1:0] app_req_len;
    logic            app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd;
    logic [QLW-1:0]  rdq_level;

    int nvec = 0, nerr = 0;
    int ptr_m;
    int tagq[$];
    int lenq[$];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_addr[i*AW +: AW]     = r_addr[i];
            ch_len[i*LENW +: LENW]  = r_len[i];
            ch_wdata[i*DW +: DW]    = r_wdata[i];
        end
    end

    sdram_req_arb #(
        .NCH(NCH), .AW(AW), .DW(DW), .LENW(LENW), .RDQ_DEPTH(RDQ_DEPTH), .RD_TAIL(RD_TAIL)
    ) dut (
        .clk(clk), .reset(reset), .mem_ready(mem_ready),
        .ch_req(ch_req), .ch_wr_n(ch_wr_n), .ch_addr(ch_addr), .ch_len(ch_len), .ch_wdata(ch_wdata),
        .ch_ack(ch_ack), .ch_wr_next(ch_wr_next), .ch_rd_valid(ch_rd_valid), .ch_rd_last(ch_rd_last),
        .rd_data(rd_data), .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
        .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack), .app_wr_data(app_wr_data),
        .app_wr_next_req(app_wr_next_req), .app_last_wr(app_last_wr), .app_rd_valid(app_rd_valid),
        .app_last_rd(app_last_rd), .app_rd_data(app_rd_data), .rdq_level(rdq_level)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Channel 0 if requesting, else the requester at the smallest forward distance from ptr.
    function automatic int model_pick(input logic [NCH-1:0] m, input int p);
        int best = -1;
        int bestd = NCH;
        if (m[0]) return 0;
        for (int c = 1; c < NCH; c++) begin
            if (m[c]) begin
                int d = (c - p + NCH - 1) % (NCH - 1);
                if (d < bestd) begin bestd = d; best = c; end
            end
        end
        return best;
    endfunction

    task automatic set_req(input int c, input logic wr_n, input logic [AW-1:0] a, input logic [LENW-1:0] l);
        ch_wr_n[c] = wr_n;
        r_addr[c]  = a;
        r_len[c]   = l;
        r_wdata[c] = DW'($urandom);
        ch_req[c]  = 1'b1;
    endtask

    task automatic do_grant(input int c, output int cnt);
        logic [LENW-1:0] el;
        int stall;
        cnt = 0;
        while (!app_req && cnt < 64) begin @(posedge clk); #1; cnt++; end
        stall = $urandom_range(0, 2);
        repeat (stall) begin @(posedge clk); #1; end
        el = (r_len[c] == '0) ? LENW'(1) : r_len[c];
        chk("app_req_held", 64'(app_req), 64'(1));
        chk("app_req_addr", 64'(app_req_addr), 64'(r_addr[c]));
        chk("app_req_len", 64'(app_req_len), 64'(el));
        chk("app_req_wr_n", 64'(app_req_wr_n), 64'(ch_wr_n[c]));
        app_req_ack = 1'b1;
        #1;
        chk("ch_ack", 64'(ch_ack), 64'(NCH'(1) << c));
        @(posedge clk); #1;
        app_req_ack = 1'b0;
        ch_req[c]   = 1'b0;
        ptr_m = (c % (NCH - 1)) + 1;
        if (ch_wr_n[c]) begin
            tagq.push_back(c);
            lenq.push_back(int'(el));
        end
    endtask

    task automatic ret_head(input int base);
        int t, n;
        logic [DW-1:0] d;
        logic [NCH-1:0] oh;
        t  = tagq[0];
        n  = lenq[0];
        oh = NCH'(1) << t;
        for (int k = 0; k < n; k++) begin
            d = (base < 0) ? DW'($urandom) : DW'(base + k);
            app_rd_valid = 1'b1;
            app_last_rd  = (k == n - 1);
            app_rd_data  = d;
            @(posedge clk); #1;
            chk("ch_rd_valid", 64'(ch_rd_valid), 64'(oh));
            chk("ch_rd_last", 64'(ch_rd_last), (k == n - 1) ? 64'(oh) : 64'(0));
            chk("rd_data", 64'(rd_data), 64'(d));
        end
        app_rd_valid = 1'b0;
        app_last_rd  = 1'b0;
        void'(tagq.pop_front());
        void'(lenq.pop_front());
        chk("rdq_level", 64'(rdq_level), 64'(tagq.size()));
    endtask

    task automatic wr_phase(input int c, input int n);
        for (int k = 0; k < n; k++) begin
            r_wdata[c]      = DW'($urandom);
            app_wr_next_req = 1'b1;
            app_last_wr     = (k == n - 1);
            #1;
            chk("ch_wr_next", 64'(ch_wr_next), 64'(NCH'(1) << c));
            chk("app_wr_data", 64'(app_wr_data), 64'(r_wdata[c]));
            @(posedge clk); #1;
        end
        chk("wr_next_after_last", 64'(ch_wr_next), 64'(0));
        app_wr_next_req = 1'b0;
        app_last_wr     = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, w, other;
        reset = 1'b1; mem_ready = 1'b0; ch_req = '0; ch_wr_n = '1;
        app_req_ack = 1'b0; app_wr_next_req = 1'b0; app_last_wr = 1'b0;
        app_rd_valid = 1'b0; app_last_rd = 1'b0; app_rd_data = '0;
        for (int i = 0; i < NCH; i++) begin r_addr[i] = '0; r_len[i] = '0; r_wdata[i] = '0; end
        ptr_m = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_app_req", 64'(app_req), 64'(0));
        chk("rst_app_req_wr_n", 64'(app_req_wr_n), 64'(1));
        chk("rst_app_req_addr", 64'(app_req_addr), 64'(0));
        chk("rst_app_req_len", 64'(app_req_len), 64'(0));
        chk("rst_rdq_level", 64'(rdq_level), 64'(0));
        chk("rst_rd_valid", 64'(ch_rd_valid), 64'(0));
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        reset = 1'b0;

        // No grant while the controller is not ready
        set_req(0, 1'b1, 25'h000100, 9'd8);
        set_req(1, 1'b1, 25'h000200, 9'd8);
        repeat (5) @(posedge clk);
        #1;
        chk("no_grant_mem_ready_low", 64'(app_req), 64'(0));
        mem_ready = 1'b1;

        // Read pipelining: ch0 then ch1, second grant one cycle after the first ack
        w = model_pick(ch_req, ptr_m); do_grant(w, cnt);
        w = model_pick(ch_req, ptr_m); do_grant(w, cnt);
        chk("pipelined_grant_gap", 64'(cnt), 64'(1));
        chk("rdq_level_peak", 64'(rdq_level), 64'(2));
        ret_head(0);
        ret_head(8);

        // Priority: ch0 beats ch2 when both request together; zero length issued as 1
        set_req(2, 1'b1, AW'($urandom), 9'd0);
        set_req(0, 1'b1, AW'($urandom), LENW'($urandom_range(1, 4)));
        w = model_pick(ch_req, ptr_m); do_grant(w, cnt);
        w = model_pick(ch_req, ptr_m); do_grant(w, cnt);
        ret_head(-1);
        ret_head(-1);

        // Round-robin with ch1/ch2 requesting continuously, filling the read queue
        set_req(1, 1'b1, AW'($urandom), LENW'($urandom_range(1, 4)));
        set_req(2, 1'b1, AW'($urandom), LENW'($urandom_range(1, 4)));
        for (int i = 0; i < RDQ_DEPTH; i++) begin
            w = model_pick(ch_req, ptr_m);
            do_grant(w, cnt);
            set_req(w, 1'b1, AW'($urandom), LENW'($urandom_range(1, 4)));
        end

        // Queue full: further reads held off until a burst completes
        repeat (6) @(posedge clk);
        #1;
        chk("full_holdoff", 64'(app_req), 64'(0));
        chk("full_level", 64'(rdq_level), 64'(RDQ_DEPTH));
        ret_head(-1);
        w = model_pick(ch_req, ptr_m);
        do_grant(w, cnt);
        chk("full_regrant_within_2", 64'(cnt <= 2), 64'(1));
        while (tagq.size() > 0) begin
            ret_head(-1);
            if (ch_req != '0) begin
                other = model_pick(ch_req, ptr_m);
                do_grant(other, cnt);
            end
        end

        // Write guard: write waits for empty queue plus RD_TAIL idle cycles
        set_req(0, 1'b1, AW'($urandom), 9'd2);
        w = model_pick(ch_req, ptr_m); do_grant(w, cnt);
        set_req(1, 1'b0, AW'($urandom), 9'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("wr_blocked_by_queue", 64'(app_req), 64'(0));
        ret_head(-1);
        do_grant(1, cnt);
        chk("wr_tail_gap", 64'(cnt), 64'(RD_TAIL + 1));
        wr_phase(1, 1);

        // Multi-word write from ch2
        set_req(2, 1'b0, AW'($urandom), 9'd3);
        w = model_pick(ch_req, ptr_m); do_grant(w, cnt);
        wr_phase(2, 3);

        // Reset in the middle of a write burst
        set_req(2, 1'b0, AW'($urandom), 9'd4);
        w = model_pick(ch_req, ptr_m); do_grant(w, cnt);
        app_wr_next_req = 1'b1;
        #1;
        chk("pre_reset_wr_next", 64'(ch_wr_next), 64'(NCH'(1) << 2));
        reset = 1'b1;
        #1;
        chk("mid_rst_app_req", 64'(app_req), 64'(0));
        chk("mid_rst_app_req_wr_n", 64'(app_req_wr_n), 64'(1));
        chk("mid_rst_wr_next", 64'(ch_wr_next), 64'(0));
        chk("mid_rst_wr_data", 64'(app_wr_data), 64'(0));
        chk("mid_rst_level", 64'(rdq_level), 64'(0));
        app_wr_next_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        ptr_m = 1;
        tagq.delete();
        lenq.delete();
        set_req(1, 1'b1, AW'($urandom), 9'd3);
        w = model_pick(ch_req, ptr_m); do_grant(w, cnt);
        ret_head(-1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
